// File: rtl/seq_adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential ripple adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // A zero chunk width is rejected by the top; return 1 so elaboration reaches that check.
    function automatic int nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from a chain of full adders.
// Also exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_ripple_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin_i;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
            assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
        end
    endgenerate

    assign cout_o = carry[CHUNK];
    assign cmsb_o = carry[CHUNK-1];

endmodule

// File: rtl/seq_ripple_adder.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit ripple slice per clock, carry held in a register.
// Define ADDER_SUB_EN to add the sub port (a + ~b + 1 when sub=1, cin ignored).
module seq_ripple_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_cfg
            $error("seq_ripple_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             of_q, of_d;

    logic             sub_sel;
    int               off;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    logic             ch_cmsb;

`ifdef ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign off = int'(idx_q) * CHUNK;

    // One adder instance serves every chunk; the counter steers which slice it sees.
    chunk_ripple_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i    (a_q[off +: CHUNK]),
        .b_i    (b_q[off +: CHUNK]),
        .cin_i  (carry_q),
        .sum_o  (ch_sum),
        .cout_o (ch_cout),
        .cmsb_o (ch_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            of_q    <= of_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        of_d    = of_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is folded in at capture: store ~b and seed the carry with 1.
                    a_d     = a;
                    b_d     = sub_sel ? ~b : b;
                    carry_d = sub_sel ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d[off +: CHUNK] = ch_sum;
                carry_d             = ch_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = ch_cout;
                    of_d    = ch_cmsb ^ ch_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign of        = of_q;

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Scoreboard bench: drivers push expected results, monitors pop and compare on each out handshake.
module tb_seq_ripple_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        of;
        int          acc;
    } exp_t;

    localparam int NCH = 4;

    localparam logic [31:0] ALT_A  [2][3] = '{'{32'hffffffff, 32'h7fffffff, 32'h00000000},
                                              '{32'h00000000, 32'h00007fff, 32'h0000ffff}};
    localparam logic [31:0] ALT_B  [2][3] = '{'{32'hffffffff, 32'h00000001, 32'h00000000},
                                              '{32'h0000ffff, 32'h00000001, 32'h00000001}};
    localparam logic        ALT_C  [2][3] = '{'{1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0}};
    localparam logic [31:0] ALT_S  [2][3] = '{'{32'hfffffffe, 32'h80000000, 32'h00000001},
                                              '{32'h0000ffff, 32'h00008000, 32'h00000000}};
    localparam logic        ALT_CO [2][3] = '{'{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b0, 1'b1}};
    localparam logic        ALT_OF [2][3] = '{'{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic        rst_n, alt_rst_n;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, of;
    logic [31:0] a, b, sum;
`ifdef ADDER_SUB_EN
    logic        sub;
`endif

    exp_t exp_q[$];
    logic ov_prev = 1'b0;

    seq_ripple_adder #(
        .WIDTH (32),
        .CHUNK (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .of        (of)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) fail_now("unexpected_out_valid");
                else chk("latency", 32'(cyc - exp_q[0].acc), NCH);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("result_without_request");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("result sum=%h cout=%b of=%b (expected %h %b %b)", sum, cout, of, e.sum, e.cout, e.of);
                    chk("sum", sum, e.sum);
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("of", 32'(of), 32'(e.of));
                end
            end
        end
        ov_prev <= out_valid;
    end

    // Called in the phase just after a rising edge; returns in the same phase after the accept edge.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                        input logic [31:0] es, input logic ec, input logic eo);
        exp_t e;
        int   n;
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        e.sum  = es;
        e.cout = ec;
        e.of   = eo;
        e.acc  = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_alt
            localparam int AW = (gi == 0) ? 32 : 16;
            localparam int AC = (gi == 0) ? 32 : 4;
            localparam int AN = AW / AC;

            logic          v_in_valid, v_in_ready, v_cin, v_out_valid, v_out_ready, v_cout, v_of;
            logic [AW-1:0] v_a, v_b, v_sum;
`ifdef ADDER_SUB_EN
            logic          v_sub;
            assign v_sub = 1'b0;
`endif
            exp_t q[$];
            logic ovp  = 1'b0;
            bit   done = 1'b0;

            seq_ripple_adder #(
                .WIDTH (AW),
                .CHUNK (AC)
            ) u_dut (
                .clk       (clk),
                .rst_n     (alt_rst_n),
                .in_valid  (v_in_valid),
                .in_ready  (v_in_ready),
                .a         (v_a),
                .b         (v_b),
                .cin       (v_cin),
`ifdef ADDER_SUB_EN
                .sub       (v_sub),
`endif
                .out_valid (v_out_valid),
                .out_ready (v_out_ready),
                .sum       (v_sum),
                .cout      (v_cout),
                .of        (v_of)
            );

            always @(negedge clk) begin
                if (alt_rst_n) begin
                    if (v_out_valid && !ovp) begin
                        if (q.size() == 0) fail_now("alt_unexpected_out_valid");
                        else chk("alt_latency", 32'(cyc - q[0].acc), AN);
                    end
                    if (v_out_valid && v_out_ready) begin
                        if (q.size() == 0) begin
                            fail_now("alt_result_without_request");
                        end else begin
                            exp_t e;
                            e = q.pop_front();
                            $display("alt W=%0d C=%0d sum=%h cout=%b of=%b (expected %h %b %b)",
                                     AW, AC, v_sum, v_cout, v_of, e.sum, e.cout, e.of);
                            chk("alt_sum", 32'(v_sum), e.sum);
                            chk("alt_cout", 32'(v_cout), 32'(e.cout));
                            chk("alt_of", 32'(v_of), 32'(e.of));
                        end
                    end
                end
                ovp <= v_out_valid;
            end

            initial begin
                exp_t e;
                int   n;
                v_in_valid  = 1'b0;
                v_out_ready = 1'b1;
                v_a         = '0;
                v_b         = '0;
                v_cin       = 1'b0;
                n = 0;
                while (alt_rst_n !== 1'b1 && n < 100) begin
                    @(posedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                for (int k = 0; k < 3; k++) begin
                    v_a        = AW'(ALT_A[gi][k]);
                    v_b        = AW'(ALT_B[gi][k]);
                    v_cin      = ALT_C[gi][k];
                    v_in_valid = 1'b1;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!v_in_ready && n < 200);
                    if (!v_in_ready) fail_now("alt_accept_timeout");
                    e.sum  = ALT_S[gi][k];
                    e.cout = ALT_CO[gi][k];
                    e.of   = ALT_OF[gi][k];
                    e.acc  = cyc + 1;
                    q.push_back(e);
                    @(posedge clk);
                    #1 v_in_valid = 1'b0;
                end
                n = 0;
                while (q.size() != 0 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (q.size() != 0) fail_now("alt_drain_timeout");
                done = 1'b1;
            end
        end
    endgenerate

    initial begin
        int n;
        rst_n     = 1'b0;
        alt_rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef ADDER_SUB_EN
        sub       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_sum", sum, 0);
        chk("reset_cout", 32'(cout), 0);
        chk("reset_of", 32'(of), 0);
        rst_n     = 1'b1;
        alt_rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'h7fffffff, 32'h7fffffff, 1'b0, 32'hfffffffe, 1'b0, 1'b1);
        send(32'h8fffffff, 32'h8fffffff, 1'b0, 32'h1ffffffe, 1'b1, 1'b1);
        send(32'h000007aa, 32'hffffffff, 1'b0, 32'h000007a9, 1'b1, 1'b0);
        send(32'h00000001, 32'hffffffff, 1'b0, 32'h00000000, 1'b1, 1'b0);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        send(32'h12345678, 32'h9abcdef0, 1'b1, 32'hacf13569, 1'b0, 1'b0);
        drain();

        // Back-pressure: result must hold while new operands wait at the input.
        out_ready = 1'b0;
        send(32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("bp_done_timeout");
        @(posedge clk);
        #1;
        a        = 32'h11111111;
        b        = 32'h22222222;
        cin      = 1'b0;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_sum", sum, 32'h00000008);
            chk("bp_cout", 32'(cout), 0);
            chk("bp_of", 32'(of), 0);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h11111111, 32'h22222222, 1'b0, 32'h33333333, 1'b0, 1'b0);
        drain();

        // Reset after two chunks of an operation; it must be discarded.
        send(32'h12345678, 32'h9abcdef0, 1'b1, 32'hacf13569, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_out_valid", 32'(out_valid), 0);
        chk("midreset_sum", sum, 0);
        chk("midreset_in_ready", 32'(in_ready), 1);
        chk("midreset_cout", 32'(cout), 0);
        chk("midreset_of", 32'(of), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(32'h000000af, 32'h000000af, 1'b1, 32'h0000015f, 1'b0, 1'b0);
        drain();

`ifdef ADDER_SUB_EN
        sub = 1'b1;
        send(32'h000007aa, 32'h00000001, 1'b0, 32'h000007a9, 1'b1, 1'b0);
        send(32'h80000000, 32'h00000001, 1'b0, 32'h7fffffff, 1'b1, 1'b1);
        send(32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0);
        sub = 1'b0;
        drain();
`endif

        n = 0;
        while (!(g_alt[0].done && g_alt[1].done) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_alt[0].done && g_alt[1].done)) fail_now("alt_configs_timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_ripple_adder.md
# seq_ripple_adder

Parametrised multi-cycle ripple-carry adder with signed-overflow detection. Operands are accepted over a valid/ready handshake and added CHUNK bits per clock, carry held in a register between chunks. The result is presented over a second valid/ready handshake. This is the area-lean, width-generic successor to the 32-bit single-cycle ripple adder, for datapaths where latency is cheaper than a full-width carry chain.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK (elaboration error otherwise)
- CHUNK, 8, bits added per cycle; NCHUNK = WIDTH/CHUNK (1 ≤ NCHUNK)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept; equals (state==IDLE)
- a  in  WIDTH  operand A (two's complement)
- b  in  WIDTH  operand B (two's complement)
- cin  in  1  carry in
- sub  in  1  subtract select (only with ADDER_SUB_EN)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result, low WIDTH bits
- cout  out  1  carry out of bit WIDTH-1
- of  out  1  signed overflow

## Operation
- States: IDLE, BUSY, DONE. Chunk counter idx, 0..NCHUNK-1.
- IDLE: in_ready=1. On in_valid&&in_ready, register a, b, cin. Clear idx. Go to BUSY.
- BUSY: each cycle add a_r[idx], b_r[idx] and the carry register. Write sum chunk idx and update the carry register.
  - idx < NCHUNK-1: idx++.
  - idx == NCHUNK-1: latch cout = final carry and of = carry-into-MSB XOR cout. Go to DONE.
- DONE: out_valid=1. sum, cout and of are held stable until out_ready. Then go to IDLE.
- in_ready is 0 in BUSY and DONE. in_valid there is ignored; no operand is lost or queued.
- Arithmetic is modulo 2^WIDTH. cout and of follow standard two's-complement rules:
  - 7fffffff+7fffffff → of=1, cout=0
  - 8fffffff+8fffffff → of=1, cout=1
- sum carries partial results during BUSY. It is meaningful only while out_valid=1.
- Reset, in any state, mid-operation included: state=IDLE, idx=0, carry=0, sum=0, cout=0, of=0, out_valid=0.
  - in_ready reads 1, but no transfer occurs while rst_n=0.
  - An in-flight operation is discarded.

## Timing
- Accept at edge T0. Chunk k is computed at edge T0+1+k. out_valid rises after edge T0+NCHUNK.
- Latency is NCHUNK cycles, accept to out_valid.
- out_valid and out_ready both high at edge Td: out_valid=0 and in_ready=1 after Td. The next accept is at Td+1 at the earliest.
- Throughput is one operation per NCHUNK+2 cycles with no back-pressure.
- out_ready low holds DONE indefinitely, with outputs constant.
- The critical path is one CHUNK-bit ripple chain plus the carry register.

## Configuration
- ADDER_SUB_EN defined:
  - The sub port exists and is registered with the operands.
  - sub=1 computes a + ~b + 1; cin is ignored.
  - cout is the "no borrow" flag. of is computed by the same rule on the inverted b.
- ADDER_SUB_EN undefined: the sub port is absent and the block always computes a + b + cin.

## Structure
- Package seq_adder_pkg holds:
  - the state enum type (IDLE/BUSY/DONE)
  - an nchunk(WIDTH, CHUNK) function
  - a clog2-based counter width helper
- One sub-module, chunk_ripple_adder:
  - combinational, parametrised by CHUNK
  - a chain of full adders
  - outputs: chunk sum, carry out, and carry into the top bit (for of)
- A single instance is reused every cycle via muxed operand slices.

## Test plan
- WIDTH=32, CHUNK=8. a=7fffffff, b=7fffffff, cin=0 → sum=fffffffe, cout=0, of=1. out_valid 4 cycles after accept.
- a=8fffffff, b=8fffffff → sum=1ffffffe, cout=1, of=1. Then a=000007AA, b=ffffffff → 000007a9, cout=1, of=0.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE and drive in_valid=1 with new operands. Required:
  - sum, cout and of stay constant
  - in_ready stays 0
  - the second operand is accepted only after the out handshake
- Reset mid-BUSY: after 2 chunks, pulse rst_n low. Required immediately: out_valid=0, sum=0, in_ready=1. Then a=000000AF, b=000000AF, cin=1 → 0000015f, cout=0, of=0.
- WIDTH=32, CHUNK=32: a=ffffffff, b=ffffffff → fffffffe, cout=1, of=0, latency 1 cycle. WIDTH=16, CHUNK=4: a=0000, b=ffff → ffff, cout=0.
- ADDER_SUB_EN, WIDTH=32, CHUNK=8:
  - sub=1, a=000007AA, b=00000001 → 000007a9, cout=1, of=0
  - sub=1, a=80000000, b=00000001 → 7fffffff, of=1
